// File: rtl/neuron_mac_sequencer.sv
// Per-neuron multiply-accumulate sequencer: streams weights and bias from the weight/bias memory,
// accumulates x*w, adds the bias and emits one saturated Q8.8 pre-activation per neuron.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; x and neuron count latched on accept
// WEIGHT | one weight read per cycle, previous weight's product added
// BIAS   | bias read issued, last weight's product added
// ADDB   | bias added, result saturated and emitted
module neuron_mac_sequencer #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [5:0]              n_count,
    input  logic [16*N_INPUTS-1:0]  x_in,
    output logic [5:0]              mem_n,
    output logic [5:0]              mem_i,
    output logic                    weight_en,
    output logic                    bias_en,
    input  logic [15:0]             mem_data,
    output logic                    out_valid,
    output logic [5:0]              out_neuron,
    output logic [15:0]             out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int I_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int N_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int C_W   = $clog2(N_NEURONS + 1);
    localparam int ACC_W = 32 + $clog2(N_INPUTS) + 1;
    localparam int SUM_W = ACC_W + 1;

    localparam logic [I_W-1:0]          LAST_I  = I_W'(N_INPUTS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SUM_W'(32768);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WEIGHT = 2'd1,
        S_BIAS   = 2'd2,
        S_ADDB   = 2'd3
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [N_W-1:0]            n_q;
    logic [I_W-1:0]            i_q;
    logic [C_W-1:0]            cnt_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [15:0]        x_q [N_INPUTS];

    logic [C_W-1:0]            cnt_clamped;
    logic                      more_neurons;
    logic signed [15:0]        x_sel;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   acc_add;
    logic signed [SUM_W-1:0]   bias_sh;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   sum_sh;
    logic [15:0]               sat_res;

    always_comb begin
        cnt_clamped = '0;
        if (n_count > 6'(N_NEURONS)) begin
            cnt_clamped = C_W'(N_NEURONS);
        end else begin
            cnt_clamped = n_count[C_W-1:0];
        end
    end

    assign more_neurons = (C_W'(n_q) + C_W'(1)) < cnt_q;

    // Data arriving now belongs to the strobe issued one cycle earlier, hence x[i-1].
    always_comb begin
        x_sel = x_q[N_INPUTS-1];
        if (state_q == S_WEIGHT) begin
            x_sel = x_q[i_q - I_W'(1)];
        end
    end

    assign prod    = 32'(x_sel) * 32'($signed(mem_data));
    assign acc_add = acc_q + ACC_W'(prod);
    assign bias_sh = SUM_W'($signed(mem_data)) <<< 8;
    assign sum     = SUM_W'(acc_q) + bias_sh;
    assign sum_sh  = sum >>> 8;

    always_comb begin
        sat_res = sum_sh[15:0];
        if (sum_sh > SAT_MAX) begin
            sat_res = 16'h7FFF;
        end else if (sum_sh < SAT_MIN) begin
            sat_res = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        weight_en = 1'b0;
        bias_en   = 1'b0;
        mem_n     = '0;
        mem_i     = '0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start && (cnt_clamped != '0)) begin
                    state_d = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                weight_en = 1'b1;
                mem_n     = 6'(n_q);
                mem_i     = 6'(i_q);
                if (i_q == LAST_I) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                bias_en = 1'b1;
                mem_n   = 6'(n_q);
                state_d = S_ADDB;
            end
            S_ADDB: begin
                state_d = more_neurons ? S_WEIGHT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            i_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_valid  <= 1'b0;
            out_neuron <= '0;
            out_data   <= '0;
            done       <= 1'b0;
            for (int g = 0; g < N_INPUTS; g++) begin
                x_q[g] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int g = 0; g < N_INPUTS; g++) begin
                            x_q[g] <= x_in[16*g +: 16];
                        end
                        cnt_q <= cnt_clamped;
                        n_q   <= '0;
                        i_q   <= '0;
                        acc_q <= '0;
                        if (cnt_clamped == '0) begin
                            done <= 1'b1;
                        end
                    end
                end
                S_WEIGHT: begin
                    if (i_q != '0) begin
                        acc_q <= acc_add;
                    end
                    i_q <= i_q + I_W'(1);
                end
                S_BIAS: begin
                    acc_q <= acc_add;
                    i_q   <= '0;
                end
                S_ADDB: begin
                    out_data   <= sat_res;
                    out_neuron <= 6'(n_q);
                    out_valid  <= 1'b1;
                    if (more_neurons) begin
                        n_q   <= n_q + N_W'(1);
                        acc_q <= '0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer: memory model with one-cycle read latency,
// arithmetic reference model and cycle-exact schedule checks.
module tb_neuron_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  n_count;
    logic [63:0] x_in;
    logic [5:0]  mem_n;
    logic [5:0]  mem_i;
    logic        weight_en;
    logic        bias_en;
    logic [15:0] mem_data;
    logic        out_valid;
    logic [5:0]  out_neuron;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] w_mem [8][4];
    logic [15:0] b_mem [8];
    logic [15:0] x_lat [4];
    logic [15:0] res [8];
    logic [15:0] res_prev [8];
    logic [15:0] last_out;

    neuron_mac_sequencer #(.N_INPUTS(4), .N_NEURONS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_count    (n_count),
        .x_in       (x_in),
        .mem_n      (mem_n),
        .mem_i      (mem_i),
        .weight_en  (weight_en),
        .bias_en    (bias_en),
        .mem_data   (mem_data),
        .out_valid  (out_valid),
        .out_neuron (out_neuron),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after a strobe; otherwise the bus carries junk.
    always @(posedge clk) begin
        if (weight_en) mem_data <= w_mem[mem_n[2:0]][mem_i[1:0]];
        else if (bias_en) mem_data <= b_mem[mem_n[2:0]];
        else mem_data <= 16'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(x_lat[i])) * longint'($signed(w_mem[n][i]));
        end
        s += longint'($signed(b_mem[n])) * 256;
        s = s >>> 8;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic fill_mem(input logic [15:0] w, input logic [15:0] b);
        for (int n = 0; n < 8; n++) begin
            b_mem[n] = b;
            for (int i = 0; i < 4; i++) w_mem[n][i] = w;
        end
    endtask

    task automatic rand_mem();
        for (int n = 0; n < 8; n++) begin
            b_mem[n] = 16'(int'($urandom_range(0, 4095)) - 2048);
            for (int i = 0; i < 4; i++)
                w_mem[n][i] = 16'((n*4 + i)*32 - 512 + int'($urandom_range(0, 31)));
        end
    endtask

    function automatic logic [63:0] rand_x();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[16*i +: 16] = 16'(int'($urandom_range(0, 4095)) - 2048);
        return v;
    endfunction

    // Caller is at a negedge; start is presented immediately and the whole run is checked cycle by cycle.
    task automatic do_run(input logic [5:0] ncnt, input logic [63:0] xv, input bit mid_start);
        int eff;
        bit exp_w, exp_b, exp_v;
        int m, nb;
        eff = (ncnt > 6'd8) ? 8 : int'(ncnt);
        for (int i = 0; i < 4; i++) x_lat[i] = xv[16*i +: 16];
        start   = 1'b1;
        n_count = ncnt;
        x_in    = xv;
        @(posedge clk);
        #1;
        start   = 1'b0;
        x_in    = {$urandom, $urandom};
        n_count = 6'($urandom_range(1, 8));
        for (int k = 0; k <= 6*eff; k++) begin
            @(negedge clk);
            m = k % 6;
            nb = k / 6;
            exp_w = (k < 6*eff) && (m < 4);
            exp_b = (k < 6*eff) && (m == 4);
            exp_v = (k > 0) && (m == 0);
            check("weight_en", 64'(weight_en), 64'(exp_w));
            check("bias_en", 64'(bias_en), 64'(exp_b));
            check("strobe_excl", 64'(weight_en & bias_en), 64'(0));
            if (exp_w) begin
                check("mem_n_w", 64'(mem_n), 64'(nb));
                check("mem_i_w", 64'(mem_i), 64'(m));
            end
            if (exp_b) check("mem_n_b", 64'(mem_n), 64'(nb));
            check("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v) begin
                check("out_neuron", 64'(out_neuron), 64'(nb - 1));
                check("out_data", 64'(out_data), 64'(ref_out(nb - 1)));
                res[nb - 1] = out_data;
                last_out    = out_data;
            end
            check("done", 64'(done), 64'(k == 6*eff));
            check("busy", 64'(busy), 64'(k < 6*eff));
            start = mid_start && (k == 8);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] xv;
        rst_n = 1'b0;
        start = 1'b0;
        n_count = '0;
        x_in = '0;
        fill_mem(16'h0000, 16'h0000);
        #12;
        check("rst_outputs", {38'(0), mem_n, mem_i, weight_en, bias_en, out_valid, busy, done},
              64'(0));
        check("rst_result", {42'(0), out_neuron, out_data}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill_mem(16'h0100, 16'h0080);
        do_run(6'd1, {4{16'h0100}}, 1'b0);
        check("unit_value", 64'(last_out), 64'h0480);

        fill_mem(16'h0200, 16'h0000);
        do_run(6'd1, {4{16'hFF00}}, 1'b0);
        check("signed_value", 64'(last_out), 64'hF800);

        fill_mem(16'h0001, 16'h0000);
        do_run(6'd1, {4{16'hFFFF}}, 1'b0);
        check("floor_trunc", 64'(last_out), 64'hFFFF);

        fill_mem(16'h7F00, 16'h7FFF);
        do_run(6'd1, {4{16'h7F00}}, 1'b0);
        check("sat_pos", 64'(last_out), 64'h7FFF);

        fill_mem(16'h7F00, 16'h0000);
        do_run(6'd1, {4{16'h8000}}, 1'b0);
        check("sat_neg", 64'(last_out), 64'h8000);

        rand_mem();
        xv = rand_x();
        do_run(6'd8, xv, 1'b0);
        for (int j = 0; j < 8; j++) res_prev[j] = res[j];
        do_run(6'd9, xv, 1'b0);
        for (int j = 0; j < 8; j++) check("clamp9_vs_8", 64'(res[j]), 64'(res_prev[j]));

        do_run(6'd0, rand_x(), 1'b0);

        rand_mem();
        do_run(6'd3, rand_x(), 1'b1);

        for (int r = 0; r < 4; r++) begin
            rand_mem();
            do_run((r == 3) ? 6'd63 : 6'($urandom_range(1, 8)), rand_x(), 1'b0);
        end

        // Abort during neuron 1's bias cycle, then restart cleanly.
        fill_mem(16'h0100, 16'h0080);
        start = 1'b1;
        n_count = 6'd2;
        x_in = {4{16'h0100}};
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_bias", 64'(bias_en), 64'(1));
        check("pre_rst_mem_n", 64'(mem_n), 64'(1));
        check("pre_rst_data", 64'(out_data), 64'h0480);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {62'(0), weight_en, bias_en}, 64'(0));
        check("abort_addr", {52'(0), mem_n, mem_i}, 64'(0));
        check("abort_status", {61'(0), out_valid, busy, done}, 64'(0));
        check("abort_result", {42'(0), out_neuron, out_data}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        rand_mem();
        do_run(6'd3, rand_x(), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Sits directly downstream of the weight/bias memory and drives its address and enable inputs. For each neuron of a layer, it streams that neuron's weights and its bias out of the memory and multiplies each weight by a latched input activation. It accumulates the products, adds the bias, and emits one saturated Q8.8 neuron pre-activation per neuron to the following CORDIC activation stage.

## Interface
Parameters:
- N_INPUTS, 4: inputs per neuron; the memory's i field is 2 bits, so 1..4.
- N_NEURONS, 8: maximum neurons per run; the memory's n field is 3 bits, so 1..8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only while busy=0.
- n_count  in  6  neurons to evaluate this run; values above N_NEURONS are clamped to N_NEURONS.
- x_in  in  16*N_INPUTS  activations, Q8.8 signed; x[i] = x_in[16*i+15:16*i]; latched on accepted start.
- mem_n  out  6  neuron address to memory; bits [5:3] always 0.
- mem_i  out  6  input address to memory; bits [5:2] always 0.
- weight_en  out  1  weight read strobe.
- bias_en  out  1  bias read strobe.
- mem_data  in  16  memory read data, Q8.8 signed; valid the cycle after a strobe.
- out_valid  out  1  one-cycle pulse marking a valid result.
- out_neuron  out  6  index of the neuron in out_data.
- out_data  out  16  saturated Q8.8 result.
- busy  out  1  high from the accepted start until the run ends.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- States:
  - IDLE: waits for a start.
  - WEIGHT: issues one weight read per cycle, for i = 0..N_INPUTS-1.
  - BIAS: issues the bias read.
  - ADDB: adds the bias and produces the result.
- IDLE -> WEIGHT on start=1. At that edge the block latches x_in, latches clamp(n_count), and sets n=0, i=0, acc=0. busy goes high.
- WEIGHT:
  - Drives weight_en=1, mem_n=n, mem_i=i.
  - If i>0, adds x[i-1]*mem_data to acc.
  - i increments each cycle. After the i=N_INPUTS-1 issue, the state goes to BIAS.
- BIAS:
  - Drives bias_en=1, mem_n=n, weight_en=0.
  - Adds x[N_INPUTS-1]*mem_data to acc.
  - Goes to ADDB.
- ADDB (no strobes):
  - sum = acc + (sign-extended mem_data << 8).
  - out_data <= sat16(sum >>> 8).
  - out_neuron <= n, out_valid <= 1.
  - If n+1 < count: n++, i=0, acc=0, go to WEIGHT. Otherwise go to IDLE and assert done <= 1 in the same edge as the final out_valid.
- Arithmetic:
  - Each product is 16x16 signed, giving 32-bit Q16.16.
  - acc is signed, 32+clog2(N_INPUTS)+1 bits wide, so it cannot overflow.
  - The >>> is an arithmetic shift and truncates toward minus infinity.
  - sat16 clamps to the range [0x8000, 0x7FFF].
- count=0: IDLE -> IDLE. done pulses the cycle after start. No strobes are issued and there is no out_valid.
- start while busy=1: ignored, with no effect on the run or on the latched inputs.
- weight_en, bias_en, mem_n and mem_i are decoded from registered state only, with no combinational path from any input. weight_en and bias_en are never high together.
- Reset mid-run: the block aborts immediately to IDLE. All outputs go low asynchronously, including the strobes.

## Timing
- Reset values: every output is 0, state=IDLE, acc=0.
- The memory returns data one cycle after a strobe. mem_data is don't-care in any cycle that does not follow a strobe.
- Counting start sampled at edge E0:
  - Weight strobes are high for the cycles after E0 through E(N_INPUTS-1).
  - The bias strobe is high in the following cycle.
  - The first out_valid is visible N_INPUTS+2 cycles after E0; with defaults, that is cycle 6.
- Throughput: one result every N_INPUTS+2 cycles. out_valid for neuron n overlaps the first WEIGHT cycle of neuron n+1.
- Run length: count*(N_INPUTS+2) cycles. busy falls on the same edge that raises the final out_valid and done.
- A new start is accepted in the cycle in which done is visible.

## Test plan
- Unit values: all x=0x0100, all w=0x0100, b=0x0080, n_count=1 -> a single out_valid at cycle 6 with out_data=0x0480 and out_neuron=0; done coincides with it.
- Signed operands: x=0xFF00 (-1.0), w=0x0200 (2.0), b=0x0000 -> out_data=0xF800 (-8.0). With x=0xFFFF and w=0x0001, b=0 -> 0xFFFF, which confirms truncation toward minus infinity.
- Saturation: x=w=0x7F00 with b=0x7FFF -> out_data=0x7FFF. x=0x8000 with w=0x7F00 -> out_data=0x8000.
- Full layer: n_count=8 with distinct weights per (n,i) in the memory model. Check:
  - 8 results at cycles 6, 12, …, 48, with out_neuron 0..7, each matching a reference model.
  - The strobe address sequence is exact.
  - weight_en and bias_en are never high together.
  - n_count=9 behaves identically to n_count=8.
- n_count=0 -> done one cycle after start, no strobes, no out_valid. A start pulse mid-run leaves the run and the latched x unchanged.
- Reset asserted during a BIAS cycle -> all outputs 0 immediately, without waiting for a clock. After release, a new start produces correct results from neuron 0.
